// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller:
// opcodes, functs, datapath select codes, FSM states and instruction classes.
package mips_pkg;

  localparam int MEM_TIMEOUT_DEF = 16;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_JR     = 6'b001000;
  localparam logic [5:0] F_ADDU   = 6'b100001;
  localparam logic [5:0] F_SUBU   = 6'b100011;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_LUI  = 3'b011;

  localparam logic [1:0] RD_RT    = 2'b00;
  localparam logic [1:0] RD_RD    = 2'b01;
  localparam logic [1:0] RD_R31   = 2'b10;

  localparam logic [1:0] WD_ALU   = 2'b00;
  localparam logic [1:0] WD_MEM   = 2'b01;
  localparam logic [1:0] WD_PC4   = 2'b10;

  localparam logic [1:0] NPC_PC4  = 2'b00;
  localparam logic [1:0] NPC_BR   = 2'b01;
  localparam logic [1:0] NPC_JT   = 2'b10;
  localparam logic [1:0] NPC_RS   = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXE    = 4'd2,
    S_MEM_RD = 4'd3,
    S_MEM_WR = 4'd4,
    S_WB_ALU = 4'd5,
    S_WB_MEM = 4'd6,
    S_BRANCH = 4'd7,
    S_JUMP   = 4'd8
  } state_e;

  typedef enum logic [3:0] {
    CL_RALU,
    CL_JR,
    CL_ORI,
    CL_LUI,
    CL_LW,
    CL_SW,
    CL_BEQ,
    CL_J,
    CL_JAL,
    CL_ILL
  } inst_cls_e;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decode: op/funct -> instruction class plus the
// execute-stage selects (extender mode, ALU source, ALU operation).
module mc_decode
  import mips_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output inst_cls_e  o_cls,
  output logic       o_extop,
  output logic       o_alusrc,
  output logic [2:0] o_aluop,
  output logic       o_legal
);

  always_comb begin
    o_cls    = CL_ILL;
    o_extop  = 1'b0;
    o_alusrc = 1'b0;
    o_aluop  = ALU_ADD;
    case (i_op)
      OP_RTYPE: begin
        case (i_funct)
          F_ADDU:  o_cls = CL_RALU;
          F_SUBU: begin
            o_cls   = CL_RALU;
            o_aluop = ALU_SUB;
          end
          F_JR:    o_cls = CL_JR;
          default: o_cls = CL_ILL;
        endcase
      end
      OP_ORI: begin
        o_cls    = CL_ORI;
        o_extop  = 1'b1;
        o_alusrc = 1'b1;
        o_aluop  = ALU_OR;
      end
      OP_LUI: begin
        o_cls    = CL_LUI;
        o_alusrc = 1'b1;
        o_aluop  = ALU_LUI;
      end
      OP_LW: begin
        o_cls    = CL_LW;
        o_alusrc = 1'b1;
      end
      OP_SW: begin
        o_cls    = CL_SW;
        o_alusrc = 1'b1;
      end
      OP_BEQ: begin
        o_cls   = CL_BEQ;
        o_aluop = ALU_SUB;
      end
      OP_J:    o_cls = CL_J;
      OP_JAL:  o_cls = CL_JAL;
      default: o_cls = CL_ILL;
    endcase
  end

  assign o_legal = (o_cls != CL_ILL);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the MIPS-subset core: sequences fetch through
// writeback, bounds data-memory waits with a timeout, and drives datapath selects.
//
// state    | meaning
// FETCH    | write IR, PC <= PC+4
// DECODE   | classify op/funct, latch decoded fields
// EXE      | ALU operation for R/I-type and address calc
// MEM_RD   | load strobe held until mem_ready (or timeout)
// MEM_WR   | store strobe held until mem_ready (or timeout)
// WB_ALU   | register write of ALU result
// WB_MEM   | register write of load data
// BRANCH   | beq compare, PC <= target when zero
// JUMP     | j / jal / jr PC update, jal links $31
module mc_ctrl
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWr,
  output logic       IRWr,
  output logic       RegWr,
  output logic       MemWr,
  output logic       MemRd,
  output logic       EXTOp,
  output logic       ALUSrc,
  output logic [2:0] ALUOp,
  output logic [1:0] RegDst,
  output logic [1:0] WDSel,
  output logic [1:0] NPCOp,
  output logic [3:0] state,
  output logic       err
);

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_e     r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic       r_err, w_set_err;
  inst_cls_e  r_cls, w_cls;
  logic       r_extop, r_alusrc, w_extop, w_alusrc, w_legal;
  logic [2:0] r_aluop, w_aluop;
  logic       w_in_mem, w_timeout;

  mc_decode u_decode (
    .i_op     (op),
    .i_funct  (funct),
    .o_cls    (w_cls),
    .o_extop  (w_extop),
    .o_alusrc (w_alusrc),
    .o_aluop  (w_aluop),
    .o_legal  (w_legal)
  );

  assign w_in_mem  = (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  assign w_timeout = w_in_mem && !mem_ready && (r_cnt == CW'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_FETCH;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_cls    <= CL_ILL;
      r_extop  <= 1'b0;
      r_alusrc <= 1'b0;
      r_aluop  <= ALU_ADD;
    end else begin
      r_state <= w_next;
      if (w_set_err) r_err <= 1'b1;
      // counter only runs while a memory access keeps waiting
      if (w_in_mem && (w_next == r_state)) r_cnt <= r_cnt + 1'b1;
      else                                 r_cnt <= '0;
      if (r_state == S_DECODE) begin
        r_cls    <= w_cls;
        r_extop  <= w_extop;
        r_alusrc <= w_alusrc;
        r_aluop  <= w_aluop;
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    w_set_err = 1'b0;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        if (!w_legal) begin
          w_next    = S_FETCH;
          w_set_err = 1'b1;
        end else begin
          case (w_cls)
            CL_J, CL_JAL, CL_JR: w_next = S_JUMP;
            CL_BEQ:              w_next = S_BRANCH;
            default:             w_next = S_EXE;
          endcase
        end
      end
      S_EXE: begin
        case (r_cls)
          CL_LW:   w_next = S_MEM_RD;
          CL_SW:   w_next = S_MEM_WR;
          default: w_next = S_WB_ALU;
        endcase
      end
      S_MEM_RD, S_MEM_WR: begin
        if (mem_ready) begin
          w_next = (r_state == S_MEM_RD) ? S_WB_MEM : S_FETCH;
        end else if (w_timeout) begin
          w_next    = S_FETCH;
          w_set_err = 1'b1;
        end
      end
      default:  w_next = S_FETCH;
    endcase
  end

  always_comb begin
    PCWr   = 1'b0;
    IRWr   = 1'b0;
    RegWr  = 1'b0;
    MemWr  = 1'b0;
    MemRd  = 1'b0;
    EXTOp  = 1'b0;
    ALUSrc = 1'b0;
    ALUOp  = ALU_ADD;
    RegDst = RD_RT;
    WDSel  = WD_ALU;
    NPCOp  = NPC_PC4;
    case (r_state)
      S_FETCH: begin
        IRWr = 1'b1;
        PCWr = 1'b1;
      end
      S_EXE: begin
        EXTOp  = r_extop;
        ALUSrc = r_alusrc;
        ALUOp  = r_aluop;
      end
      S_MEM_RD: MemRd = 1'b1;
      S_MEM_WR: MemWr = 1'b1;
      S_WB_ALU: begin
        RegWr  = 1'b1;
        RegDst = (r_cls == CL_RALU) ? RD_RD : RD_RT;
      end
      S_WB_MEM: begin
        RegWr = 1'b1;
        WDSel = WD_MEM;
      end
      S_BRANCH: begin
        ALUOp = ALU_SUB;
        if (zero) begin
          PCWr  = 1'b1;
          NPCOp = NPC_BR;
        end
      end
      S_JUMP: begin
        PCWr  = 1'b1;
        NPCOp = (r_cls == CL_JR) ? NPC_RS : NPC_JT;
        if (r_cls == CL_JAL) begin
          RegWr  = 1'b1;
          RegDst = RD_R31;
          WDSel  = WD_PC4;
        end
      end
      default: ;
    endcase
    // the cycle in which reset is sampled must not disturb PC, IR, regs or memory
    if (reset) begin
      PCWr  = 1'b0;
      IRWr  = 1'b0;
      RegWr = 1'b0;
      MemWr = 1'b0;
      MemRd = 1'b0;
    end
  end

  assign state = r_state;
  assign err   = r_err;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-instruction expected cycle traces built
// from the instruction rules, compared against the DUT every cycle.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic       PCWr, IRWr, RegWr, MemWr, MemRd, EXTOp, ALUSrc;
  logic [2:0] ALUOp;
  logic [1:0] RegDst, WDSel, NPCOp;
  logic [3:0] state;
  logic       err;

  mc_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .PCWr(PCWr), .IRWr(IRWr), .RegWr(RegWr),
    .MemWr(MemWr), .MemRd(MemRd), .EXTOp(EXTOp), .ALUSrc(ALUSrc),
    .ALUOp(ALUOp), .RegDst(RegDst), .WDSel(WDSel), .NPCOp(NPCOp),
    .state(state), .err(err)
  );

  always #5 clk = ~clk;

  logic [15:0] w_ctl;
  assign w_ctl = {PCWr, IRWr, RegWr, MemWr, MemRd, EXTOp, ALUSrc, ALUOp, RegDst, WDSel, NPCOp};

  localparam int K_ADDU = 0, K_SUBU = 1, K_JR = 2, K_ORI = 3, K_LW = 4, K_SW = 5;
  localparam int K_BEQ = 6, K_LUI = 7, K_J = 8, K_JAL = 9, K_ILL = 10;

  typedef struct packed {
    logic [3:0]  st;
    logic [15:0] ctl;
    logic        rdy;
    logic        zr;
    logic        e;
  } exp_t;

  exp_t        q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic        m_err;
  logic [5:0]  op_v, funct_v;
  string       cur_tag;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s.%s got=%0h exp=%0h t=%0t", cur_tag, tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] mk(input logic pc, ir, rw, mw, mr, ext, src,
                                     input logic [2:0] alu, input logic [1:0] rdst, wds, npc);
    return {pc, ir, rw, mw, mr, ext, src, alu, rdst, wds, npc};
  endfunction

  function automatic bit is_legal(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'b000000) return (f == 6'b100001) || (f == 6'b100011) || (f == 6'b001000);
    return o inside {6'b000010, 6'b000011, 6'b000100, 6'b001101, 6'b001111, 6'b100011, 6'b101011};
  endfunction

  function automatic void push(input logic [3:0] st, input logic [15:0] c, input logic r, input logic z);
    q.push_back('{st: st, ctl: c, rdy: r, zr: z, e: m_err});
  endfunction

  // Memory phase: ready arrives after `waits` idle cycles; 16 idle cycles abort.
  function automatic bit push_mem(input logic [3:0] st, input logic [15:0] c, input int waits);
    int n = (waits < 16) ? waits + 1 : 16;
    for (int i = 0; i < n; i++) push(st, c, (i == waits), 1'($urandom));
    return (waits < 16);
  endfunction

  task automatic build(input int kind, input int waits, input logic zr);
    bit done;
    q.delete();
    funct_v = 6'($urandom);
    case (kind)
      K_ADDU: begin op_v = 6'b000000; funct_v = 6'b100001; end
      K_SUBU: begin op_v = 6'b000000; funct_v = 6'b100011; end
      K_JR:   begin op_v = 6'b000000; funct_v = 6'b001000; end
      K_ORI:  op_v = 6'b001101;
      K_LW:   op_v = 6'b100011;
      K_SW:   op_v = 6'b101011;
      K_BEQ:  op_v = 6'b000100;
      K_LUI:  op_v = 6'b001111;
      K_J:    op_v = 6'b000010;
      K_JAL:  op_v = 6'b000011;
      default: begin
        op_v = 6'($urandom);
        while (is_legal(op_v, funct_v)) begin
          op_v = 6'($urandom);
          funct_v = 6'($urandom);
        end
      end
    endcase
    push(4'd0, mk(1,1,0,0,0,0,0,3'd0,2'd0,2'd0,2'd0), 1'($urandom), 1'($urandom));
    push(4'd1, 16'h0, 1'($urandom), 1'($urandom));
    case (kind)
      K_ADDU, K_SUBU: begin
        push(4'd2, mk(0,0,0,0,0,0,0,(kind == K_SUBU) ? 3'd1 : 3'd0,2'd0,2'd0,2'd0), 1'($urandom), 1'($urandom));
        push(4'd5, mk(0,0,1,0,0,0,0,3'd0,2'd1,2'd0,2'd0), 1'($urandom), 1'($urandom));
      end
      K_ORI, K_LUI: begin
        push(4'd2, mk(0,0,0,0,0,(kind == K_ORI),1,(kind == K_ORI) ? 3'd2 : 3'd3,2'd0,2'd0,2'd0),
             1'($urandom), 1'($urandom));
        push(4'd5, mk(0,0,1,0,0,0,0,3'd0,2'd0,2'd0,2'd0), 1'($urandom), 1'($urandom));
      end
      K_LW: begin
        push(4'd2, mk(0,0,0,0,0,0,1,3'd0,2'd0,2'd0,2'd0), 1'($urandom), 1'($urandom));
        done = push_mem(4'd3, mk(0,0,0,0,1,0,0,3'd0,2'd0,2'd0,2'd0), waits);
        if (done) push(4'd6, mk(0,0,1,0,0,0,0,3'd0,2'd0,2'd1,2'd0), 1'($urandom), 1'($urandom));
        else m_err = 1'b1;
      end
      K_SW: begin
        push(4'd2, mk(0,0,0,0,0,0,1,3'd0,2'd0,2'd0,2'd0), 1'($urandom), 1'($urandom));
        done = push_mem(4'd4, mk(0,0,0,1,0,0,0,3'd0,2'd0,2'd0,2'd0), waits);
        if (!done) m_err = 1'b1;
      end
      K_BEQ:
        push(4'd7, mk(zr,0,0,0,0,0,0,3'd1,2'd0,2'd0,zr ? 2'd1 : 2'd0), 1'($urandom), zr);
      K_J:   push(4'd8, mk(1,0,0,0,0,0,0,3'd0,2'd0,2'd0,2'd2), 1'($urandom), 1'($urandom));
      K_JAL: push(4'd8, mk(1,0,1,0,0,0,0,3'd0,2'd2,2'd2,2'd2), 1'($urandom), 1'($urandom));
      K_JR:  push(4'd8, mk(1,0,0,0,0,0,0,3'd0,2'd0,2'd0,2'd3), 1'($urandom), 1'($urandom));
      default: m_err = 1'b1;
    endcase
  endtask

  // Called at #1 after a rising edge with the DUT expected in FETCH.
  task automatic run_n(input int n);
    for (int i = 0; i < n && i < q.size(); i++) begin
      op        = (i == 0) ? 6'($urandom) : op_v;
      funct     = (i == 0) ? 6'($urandom) : funct_v;
      mem_ready = q[i].rdy;
      zero      = q[i].zr;
      #1;
      chk_val("state", 32'(state), 32'(q[i].st));
      chk_val("ctl",   32'(w_ctl), 32'(q[i].ctl));
      chk_val("err",   32'(err),   32'(q[i].e));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_instr(input string tag, input int kind, input int waits, input logic zr);
    cur_tag = tag;
    build(kind, waits, zr);
    run_n(q.size());
  endtask

  task automatic do_reset();
    cur_tag   = "reset";
    reset     = 1'b1;
    op        = '0;
    funct     = '0;
    zero      = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_val("state", 32'(state), 32'd0);
    chk_val("ctl",   32'(w_ctl), 32'd0);
    chk_val("err",   32'(err),   32'd0);
    reset = 1'b0;
    m_err = 1'b0;
  endtask

  initial begin
    int kind, waits;
    reset = 1'b1;
    m_err = 1'b0;
    do_reset();

    run_instr("ori",     K_ORI,  0, 1'b0);
    run_instr("lw_w3",   K_LW,   3, 1'b0);
    run_instr("beq_z1",  K_BEQ,  0, 1'b1);
    run_instr("beq_z0",  K_BEQ,  0, 1'b0);
    run_instr("jal",     K_JAL,  0, 1'b0);
    run_instr("jr",      K_JR,   0, 1'b0);
    run_instr("j",       K_J,    0, 1'b0);
    run_instr("addu",    K_ADDU, 0, 1'b0);
    run_instr("subu",    K_SUBU, 0, 1'b0);
    run_instr("lui",     K_LUI,  0, 1'b0);
    run_instr("lw_w15",  K_LW,  15, 1'b0);
    run_instr("sw_w2",   K_SW,   2, 1'b0);
    run_instr("sw_stuck", K_SW, 99, 1'b0);
    run_instr("after_to", K_ORI, 0, 1'b0);

    // reset while a load is waiting on memory
    cur_tag = "rst_mid_rd";
    build(K_LW, 99, 1'b0);
    run_n(4);
    reset     = 1'b1;
    mem_ready = 1'b0;
    #1;
    chk_val("state", 32'(state), 32'd3);
    chk_val("ctl",   32'(w_ctl), 32'd0);
    @(posedge clk);
    #1;
    chk_val("state", 32'(state), 32'd0);
    chk_val("ctl",   32'(w_ctl), 32'd0);
    chk_val("err",   32'(err),   32'd0);
    reset = 1'b0;
    m_err = 1'b0;

    cur_tag = "op3f";
    q.delete();
    op_v    = 6'b111111;
    funct_v = 6'($urandom);
    push(4'd0, mk(1,1,0,0,0,0,0,3'd0,2'd0,2'd0,2'd0), 1'b0, 1'b0);
    push(4'd1, 16'h0, 1'b0, 1'b0);
    m_err = 1'b1;
    run_n(q.size());
    run_instr("after_ill", K_J, 0, 1'b0);

    do_reset();
    for (int n = 0; n < 60; n++) begin
      kind  = $urandom_range(0, 10);
      waits = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 18) : $urandom_range(0, 4);
      run_instr($sformatf("rnd%0d_k%0d", n, kind), kind, waits, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
